lsu_dbus_master: RTL

- Data-side bus initiator between the MEM pipeline stage and the data memory responder.
- Accepts one load/store request at a time from MEM.
- Aligns the address to 8 bytes, lane-shifts store data and builds the byte mask, then drives the dbus read/write enables.
- Waits for the ack, then returns sign- or zero-extended load data, or an error, to MEM through a valid/ready response.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_load_align.sv | 27 ++
 rtl/lsu_dbus_master.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the data-side load/store bus initiator.
// Size encodings, FSM states and small address helpers.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  // Natural alignment check for a byte offset within a dword
  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [2:0] off
  );
    return (size == SZ_H && off[0]) ||
           (size == SZ_W && off[1:0] != 2'd0) ||
           (size == SZ_D && off != 3'd0);
  endfunction

  // Byte strobe for an access of the given size at lane 0
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    unique case (size)
      SZ_B: m = 8'h01;
      SZ_H: m = 8'h03;
      SZ_W: m = 8'h0F;
      SZ_D: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data extraction: shift the addressed bytes down
// and sign- or zero-extend them to 64 bits.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [63:0] rdata_i,
  input  logic [2:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [63:0] data_o
);

  logic [63:0] raw;
  assign raw = rdata_i >> {off_i, 3'b000};

  // Keep the low bytes for the size, fill the rest
  always_comb begin
    data_o = raw;
    unique case (size_i)
      SZ_B: data_o = {{56{~uns_i & raw[7]}}, raw[7:0]};
      SZ_H: data_o = {{48{~uns_i & raw[15]}}, raw[15:0]};
      SZ_W: data_o = {{32{~uns_i & raw[31]}}, raw[31:0]};
      SZ_D: data_o = raw;
    endcase
  end

endmodule

// File: rtl/lsu_dbus_master.sv
// Data bus initiator between the MEM stage and data memory.
// One outstanding access; registered dbus and response outputs.
module lsu_dbus_master
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_W         = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic              dbus_r_en,
  output logic              dbus_w_en,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [63:0]       dbus_wdata,
  output logic [7:0]        dbus_wmask,
  input  logic              dbus_ack,
  input  logic [63:0]       dbus_rdata
);

  lsu_state_e        state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [2:0]        off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              we_q, we_d;
  logic              ren_q, ren_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [7:0]        wmask_q, wmask_d;
  logic              rv_q, rv_d;
  logic [63:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [2:0]  req_off;
  logic [63:0] load_data;
  logic        tmo;

  assign req_off = req_addr[2:0];
  assign tmo = (TIMEOUT_CYCLES != 0) &&
               (cnt_q == TIMEOUT_CYCLES - 1);

  lsu_load_align u_align (
    .rdata_i (dbus_rdata),
    .off_i   (off_q),
    .size_i  (size_q),
    .uns_i   (uns_q),
    .data_o  (load_data)
  );

  // Next-state: accept, run the bus cycle, hold the response
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    size_d  = size_q;
    uns_d   = uns_q;
    we_d    = we_q;
    ren_d   = ren_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rv_d    = rv_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          off_d  = req_off;
          size_d = req_size;
          uns_d  = req_unsigned;
          we_d   = req_we;
          if (misaligned(req_size, req_off)) begin
            state_d = ST_RESP;
            rv_d    = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = ST_BUS;
            cnt_d   = '0;
            ren_d   = ~req_we;
            wen_d   = req_we;
            addr_d  = {req_addr[ADDR_W-1:3], 3'b000};
            wdata_d = req_wdata << {req_off, 3'b000};
            wmask_d = req_we ?
                      size_mask(req_size) << req_off :
                      8'h00;
          end
        end
      end
      ST_BUS: begin
        if (dbus_ack || tmo) begin
          state_d = ST_RESP;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          wmask_d = '0;
          rv_d    = 1'b1;
          err_d   = ~dbus_ack;
          rdata_d = (dbus_ack && !we_q) ? load_data : '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
          rv_d    = 1'b0;
          err_d   = 1'b0;
          rdata_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rv_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      we_q    <= we_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = rv_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign dbus_r_en  = ren_q;
  assign dbus_w_en  = wen_q;
  assign dbus_addr  = addr_q;
  assign dbus_wdata = wdata_q;
  assign dbus_wmask = wmask_q;

endmodule
